decodprisimples_seq: RTL and testbench

Sequenced 2-to-4 decoder: the decoding end of the simple priority-encoder path. Accepts 2-bit codes over a valid/ready handshake, queues them, and drives each as a one-hot 4-bit output held for a programmable number of cycles. Enable masking matches the encoder: `en=0` forces zero output. Sits downstream of the priority encoder, driving one-hot strobes (e.g. LED or channel select) at a paced rate.

---
 rtl/decodprisimples_seq_if.sv | 21 ++
 rtl/decodprisimples_seq.sv | 120 ++++++++++++
 tb/tb_decodprisimples_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decodprisimples_seq_if.sv
// Code handshake and decoded-output bundle for decodprisimples_seq.
// The master side offers codes and observes the one-hot output; the slave side is the decoder.
interface decodprisimples_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] y;
  logic [3:0] d;
  logic       d_valid;
  logic       busy;
  logic [3:0] count;

  modport master (
    output in_valid, y,
    input  in_ready, d, d_valid, busy, count
  );

  modport slave (
    input  in_valid, y,
    output in_ready, d, d_valid, busy, count
  );
endinterface

// File: rtl/decodprisimples_seq.sv
// Sequenced 2-to-4 one-hot decoder: each accepted code is held on d for HOLD enabled cycles.
// Define DECOD_FIFO_EN to add a FIFO_DEPTH-entry code queue; otherwise codes load only when idle.
module decodprisimples_seq #(
  parameter int unsigned HOLD       = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_en,
  decodprisimples_seq_if.slave  io_bus
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  HoldInit = 4'(HOLD - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e        r_state;
  logic [3:0]    r_d;
  logic [3:0]    r_hcnt;
  logic          r_busy;

  logic          w_transfer;
  logic          w_load;
  logic [1:0]    w_code;
  logic [PtrW:0] w_count;

  assign w_transfer = io_bus.in_valid & io_bus.in_ready;

`ifdef DECOD_FIFO_EN
  localparam logic [PtrW:0] Full = FIFO_DEPTH[PtrW:0];

  logic [1:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [PtrW:0]   r_count;
  logic            w_empty, w_full, w_slot, w_pop, w_bypass, w_push;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == Full);
  // A load slot exists when idle, or on the last cycle of the current word.
  assign w_slot   = i_en & ((r_state == StIdle) | (r_hcnt == 4'd0));
  assign w_pop    = w_slot & ~w_empty;
  assign w_bypass = w_slot & (r_state == StIdle) & w_empty & w_transfer;
  assign w_push   = w_transfer & ~w_bypass;
  assign w_load   = w_pop | w_bypass;
  assign w_code   = w_pop ? r_mem[r_rptr] : io_bus.y;
  assign w_count  = r_count;

  assign io_bus.in_ready = i_en & ~i_reset & ~w_full;

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= io_bus.y;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
`else
  assign w_load  = w_transfer;
  assign w_code  = io_bus.y;
  assign w_count = '0;

  assign io_bus.in_ready = i_en & ~i_reset & (r_state == StIdle);
`endif

  // Everything freezes while i_en is low so the word resumes exactly where it stopped.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_d     <= '0;
      r_hcnt  <= '0;
      r_busy  <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        StIdle: begin
          if (w_load) begin
            r_state <= StHold;
            r_d     <= 4'b0001 << w_code;
            r_hcnt  <= HoldInit;
            r_busy  <= 1'b1;
          end
        end
        StHold: begin
          if (r_hcnt != 4'd0) begin
            r_hcnt <= r_hcnt - 1'b1;
          end else if (w_load) begin
            r_d    <= 4'b0001 << w_code;
            r_hcnt <= HoldInit;
          end else begin
            r_state <= StIdle;
            r_d     <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.d       = r_d & {4{i_en}};
  assign io_bus.d_valid = r_busy & i_en;
  assign io_bus.busy    = r_busy;
  assign io_bus.count   = 4'(w_count);

endmodule

// File: tb/tb_decodprisimples_seq.sv
// Bench for decodprisimples_seq: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations. Works with or without DECOD_FIFO_EN.
`timescale 1ns/1ps
module tb_decodprisimples_seq;
  localparam int unsigned HOLD       = 3;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef DECOD_FIFO_EN
  localparam bit FifoEn = 1'b1;
`else
  localparam bit FifoEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  decodprisimples_seq_if bus ();

  decodprisimples_seq #(
    .HOLD       (HOLD),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_en    (en),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit started  = 1'b0;
  bit hit_full = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  // Reference model: pending codes in a queue, current word with its remaining visible cycles.
  int q[$];
  bit m_busy = 1'b0;
  int m_code = 0;
  int m_left = 0;

  function automatic bit m_ready();
    if (rst || !en) return 1'b0;
    if (FifoEn) return q.size() < FIFO_DEPTH;
    return !m_busy;
  endfunction

  always @(posedge clk) begin : model
    bit xfer;
    bit took;
    xfer = bus.in_valid && m_ready();
    took = 1'b0;
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      m_left = 0;
    end else if (en) begin
      if (m_busy && m_left > 1) begin
        m_left--;
      end else if (q.size() > 0) begin
        m_code = q.pop_front();
        m_busy = 1'b1;
        m_left = HOLD;
      end else if (!m_busy && xfer) begin
        m_code = int'(bus.y);
        m_busy = 1'b1;
        m_left = HOLD;
        took   = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      if (xfer && !took) q.push_back(int'(bus.y));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_d", bus.d, (m_busy && en) ? 4'(1 << m_code) : 4'd0);
      chk("cyc_d_valid", {3'b0, bus.d_valid}, {3'b0, m_busy && en});
      chk("cyc_busy", {3'b0, bus.busy}, {3'b0, m_busy});
      chk("cyc_count", bus.count, 4'(q.size()));
      chk("cyc_in_ready", {3'b0, bus.in_ready}, {3'b0, m_ready()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a code until accepted, bounded.
  task automatic send(input logic [1:0] code);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.y        = code;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.count == 4'(FIFO_DEPTH) && !bus.in_ready) hit_full = 1'b1;
      if (bus.in_ready) done = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", {3'b0, done}, 4'd1);
  endtask

  task automatic wait_idle();
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (!bus.busy && bus.count == 4'd0) reached = 1'b1;
      else step();
    end
    chk("idle_reached", {3'b0, reached}, 4'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.y        = 2'b00;
    rst          = 1'b1;
    en           = 1'b1;
    step();
    started = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {3'b0, bus.in_ready}, 4'd0);
    chk("rst_busy", {3'b0, bus.busy}, 4'd0);
    chk("rst_d", bus.d, 4'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {3'b0, bus.in_ready}, 4'd1);

    // Single code 2 held for exactly three cycles.
    send(2'b10);
    repeat (3) begin
      @(negedge clk);
      chk("t1_d", bus.d, 4'b0100);
      chk("t1_d_valid", {3'b0, bus.d_valid}, 4'd1);
      step();
    end
    @(negedge clk);
    chk("t1_end_d", bus.d, 4'd0);
    chk("t1_end_busy", {3'b0, bus.busy}, 4'd0);

`ifdef DECOD_FIFO_EN
    // Back-to-back codes through the queue, filling it.
    send(2'b00); send(2'b01); send(2'b10); send(2'b11);
    send(2'b00); send(2'b01); send(2'b10);
    wait_idle();
    chk("t2_full_refused", {3'b0, hit_full}, 4'd1);
`else
    // While holding code 0, code 1 waits for the idle cycle.
    send(2'b00);
    @(negedge clk);
    chk("t2_busy_in_ready", {3'b0, bus.in_ready}, 4'd0);
    chk("t2_d0", bus.d, 4'b0001);
    send(2'b01);
    @(negedge clk);
    chk("t2_d1", bus.d, 4'b0010);
    wait_idle();
`endif

    // Enable dropped for two cycles mid-hold.
    send(2'b01);
    @(negedge clk);
    chk("t3_first", bus.d, 4'b0010);
    step();
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t3_masked_d", bus.d, 4'd0);
      chk("t3_masked_dv", {3'b0, bus.d_valid}, 4'd0);
      chk("t3_masked_busy", {3'b0, bus.busy}, 4'd1);
      step();
    end
    en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t3_resumed", bus.d, 4'b0010);
      step();
    end
    @(negedge clk);
    chk("t3_end_busy", {3'b0, bus.busy}, 4'd0);

    // Disabled block refuses input.
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.y        = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("t4_in_ready", {3'b0, bus.in_ready}, 4'd0);
      chk("t4_d", bus.d, 4'd0);
      chk("t4_count", bus.count, 4'd0);
      step();
    end
    bus.in_valid = 1'b0;
    en           = 1'b1;
    @(negedge clk);
    chk("t4_no_transfer", {3'b0, bus.busy}, 4'd0);

`ifdef DECOD_FIFO_EN
    // Reset during the second hold cycle with two codes queued.
    send(2'b00); send(2'b01); send(2'b10); send(2'b11);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_count", bus.count, 4'd2);
    chk("t5_pre_d", bus.d, 4'b0010);
`else
    // Reset mid-hold.
    send(2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_d", bus.d, 4'b1000);
`endif
    step();
    @(negedge clk);
    chk("t5_d", bus.d, 4'd0);
    chk("t5_busy", {3'b0, bus.busy}, 4'd0);
    chk("t5_count", bus.count, 4'd0);
    step();
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t5_discarded", bus.d, 4'd0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
